// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder: two chained half-add steps per clock with a registered carry, LSB-first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             c;

  logic             s1, c1, s_bit, c2, c_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Full add of the current bit pair as two half-add steps against the registered carry
  always_comb begin
    s1      = a_sh[0] ^ b_sh[0];
    c1      = a_sh[0] & b_sh[0];
    s_bit   = s1 ^ c;
    c2      = s1 & c;
    c_nxt   = c1 | c2;
    res_nxt = {s_bit, res_sh};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      c         <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            c     <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          c      <= c_nxt;
          res_sh <= res_nxt[WIDTH-1:1];
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          // Last bit: c still holds the carry into the MSB, c_nxt is the carry out of it
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum_out   <= res_nxt;
            carry_out <= c_nxt;
`ifdef SERIAL_ADD_OVF_EN
            ovf_out   <= c ^ c_nxt;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit: directed cases plus randomized operands against an arithmetic model.
// Build with SERIAL_ADD_OVF_EN defined to also check the overflow output.
module tb_serial_add_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         carry_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf_out;
`endif

  int tests_run = 0;
  int failed    = 0;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_out   (ovf_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain integer addition on W+1 bits
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b};
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, then wait (bounded) for out_valid; lat = cycles from accept edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    step(); step();
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests_run++;
    if ({carry_out, sum_out} !== 9'h000) begin
      failed++; $display("FAIL reset_outputs got c=%0b s=%h want c=0 s=00", carry_out, sum_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    tests_run++;
    if (ovf_out !== 1'b0) begin failed++; $display("FAIL reset_ovf got %0b want 0", ovf_out); end
`endif
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    run_op(8'h5A, 8'h3C, lat);
    tests_run++;
    if (lat !== W) begin failed++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    tests_run++;
    if ({carry_out, sum_out} !== 9'h096) begin
      failed++; $display("FAIL basic_sum got c=%0b s=%h want c=0 s=96", carry_out, sum_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    tests_run++;
    if (ovf_out !== 1'b1) begin failed++; $display("FAIL basic_ovf got %0b want 1", ovf_out); end
`endif
    step();
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL basic_return_idle got %0b want 1", in_ready); end
  endtask

  task automatic test_carry_clear();
    int lat;
    run_op(8'hFF, 8'h01, lat);
    tests_run++;
    if ({carry_out, sum_out} !== 9'h100) begin
      failed++; $display("FAIL ff_plus_1 got c=%0b s=%h want c=1 s=00", carry_out, sum_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    tests_run++;
    if (ovf_out !== 1'b0) begin failed++; $display("FAIL ff_plus_1_ovf got %0b want 0", ovf_out); end
`endif
    consume();
    run_op(8'h00, 8'h00, lat);
    tests_run++;
    if ({carry_out, sum_out} !== 9'h000) begin
      failed++; $display("FAIL carry_cleared got c=%0b s=%h want c=0 s=00", carry_out, sum_out);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W:0] exp;
    exp = ref_add(8'hC3, 8'h77);
    run_op(8'hC3, 8'h77, lat);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({carry_out, sum_out} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failed++;
        $display("FAIL backpressure_hold cyc %0d got c=%0b s=%h rdy=%0b vld=%0b want c=%0b s=%h rdy=0 vld=1",
                 i, carry_out, sum_out, in_ready, out_valid, exp[W], exp[W-1:0]);
      end
      step();
    end
    consume();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failed++; $display("FAIL backpressure_release got rdy=%0b vld=%0b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_in_valid_ignored();
    int n;
    in_valid = 1'b1; a_in = 8'h10; b_in = 8'h20;
    step();
    n = 0;
    while (!out_valid && n < 100) begin
      a_in = W'($urandom); b_in = W'($urandom);
      step();
      n++;
    end
    tests_run++;
    if (in_ready !== 1'b0) begin failed++; $display("FAIL done_in_ready got %0b want 0", in_ready); end
    in_valid = 1'b0;
    tests_run++;
    if ({carry_out, sum_out} !== 9'h030) begin
      failed++; $display("FAIL in_valid_ignored got c=%0b s=%h want c=0 s=30", carry_out, sum_out);
    end
    consume();
  endtask

  task automatic test_reset_abort();
    int lat;
    // Leave a nonzero result on sum_out so the abort's clearing is visible
    run_op(8'h10, 8'h20, lat);
    consume();
    in_valid = 1'b1; a_in = 8'hAA; b_in = 8'h55;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {carry_out, sum_out} !== 9'h000) begin
      failed++;
      $display("FAIL reset_abort got rdy=%0b vld=%0b c=%0b s=%h want rdy=1 vld=0 c=0 s=00",
               in_ready, out_valid, carry_out, sum_out);
    end
    run_op(8'h01, 8'h01, lat);
    tests_run++;
    if ({carry_out, sum_out} !== 9'h002) begin
      failed++; $display("FAIL after_abort got c=%0b s=%h want c=0 s=02", carry_out, sum_out);
    end
    consume();
  endtask

  task automatic test_signed_edge();
    int lat;
    run_op(8'h7F, 8'h01, lat);
    tests_run++;
    if ({carry_out, sum_out} !== 9'h080) begin
      failed++; $display("FAIL 7f_plus_1 got c=%0b s=%h want c=0 s=80", carry_out, sum_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    tests_run++;
    if (ovf_out !== 1'b1) begin failed++; $display("FAIL 7f_plus_1_ovf got %0b want 1", ovf_out); end
`endif
    consume();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    for (int i = 0; i < 30; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      exp = ref_add(a, b);
      run_op(a, b, lat);
      tests_run++;
      if (lat !== W || {carry_out, sum_out} !== exp) begin
        failed++;
        $display("FAIL random %h+%h got lat=%0d c=%0b s=%h want lat=%0d c=%0b s=%h",
                 a, b, lat, carry_out, sum_out, W, exp[W], exp[W-1:0]);
      end
`ifdef SERIAL_ADD_OVF_EN
      tests_run++;
      if (ovf_out !== ref_ovf(a, b)) begin
        failed++; $display("FAIL random_ovf %h+%h got %0b want %0b", a, b, ovf_out, ref_ovf(a, b));
      end
`endif
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) step();
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_clear();
    test_backpressure();
    test_in_valid_ignored();
    test_reset_abort();
    test_signed_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/serial_add_unit.md
# serial_add_unit

Bit-serial WIDTH-bit adder. It sits directly downstream of the half-adder cell and reuses that sum/carry function once per clock, chaining two half-add steps with a registered carry to form a full add. Operands arrive through a valid/ready handshake and are processed LSB-first, one bit per cycle. The result is held on a valid/ready output until it is consumed. It gives a small-area alternative to a parallel ripple adder.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high; the only clock and reset in the block.
- in_valid  input  1  operands a_in/b_in are presented.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- a_in  input  WIDTH  operand A, unsigned.
- b_in  input  WIDTH  operand B, unsigned.
- out_valid  output  1  sum_out/carry_out hold a finished result.
- out_ready  input  1  consumer accepts the result.
- sum_out  output  WIDTH  A+B modulo 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- ovf_out  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- FSM has three states: IDLE, SHIFT, DONE. Reset forces IDLE.
- IDLE → SHIFT when in_valid && in_ready at a clock edge. On that edge:
  - load a_sh <= a_in and b_sh <= b_in;
  - clear the carry register c and the bit counter cnt;
  - keep sum_out and carry_out unchanged.
- SHIFT: on each edge, with a = a_sh[0] and b = b_sh[0]:
  - first half-add: s1 = a^b, c1 = a&b;
  - second half-add: s = s1^c, c2 = s1&c;
  - update c <= c1|c2;
  - shift s into the MSB of the result shift register (logical right shift), so after WIDTH shifts bit 0 is at LSB;
  - logical right shift a_sh and b_sh;
  - increment cnt.
- On the edge where cnt == WIDTH-1: load carry_out <= final carry, copy the result register to sum_out, and go to DONE.
- DONE: out_valid = 1. sum_out and carry_out are stable until the handshake.
  - On out_valid && out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so a new operand cannot be accepted on the same edge as result acceptance.
- in_valid in SHIFT or DONE is ignored. Operands must be re-presented once in_ready = 1.
- out_ready while not in DONE is ignored.
- Reset values: state IDLE, in_ready 1, out_valid 0, sum_out 0, carry_out 0, ovf_out 0, c 0, cnt 0.
- rst mid-SHIFT or in DONE aborts the operation. The partial result is discarded and all outputs take their reset values on that edge.
- cnt width is $clog2(WIDTH). Wrap-around is impossible because exit is at WIDTH-1.

## Timing
- Accept edge T. Bit k is processed on edge T+1+k.
- out_valid rises after edge T+WIDTH, so latency is WIDTH cycles from accept to out_valid.
- Minimum throughput is one add per WIDTH+2 cycles:
  - WIDTH shift cycles;
  - 1 DONE cycle, with out_ready tied high;
  - 1 IDLE cycle.
- in_ready and out_valid are decoded from the state register with no combinational path from in_valid or out_ready.
- Under backpressure (out_ready low), DONE holds indefinitely and outputs do not change.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - ovf_out port exists;
  - on the final SHIFT edge, ovf_out <= (carry into bit WIDTH-1) ^ (carry out of bit WIDTH-1);
  - ovf_out is held with sum_out.
- Not defined: no ovf_out port and no extra flop. All other behaviour is identical.

## Test plan
- WIDTH=8, a_in=0x5A, b_in=0x3C, out_ready=1 → out_valid exactly 8 cycles after accept; sum_out=0x96, carry_out=0, ovf_out=1.
- 0xFF + 0x01 → sum_out=0x00, carry_out=1, ovf_out=0. Then 0x00 + 0x00 → sum_out=0x00, carry_out=0, which checks that the carry is cleared between operations.
- Backpressure: out_ready=0 for 5 cycles after out_valid → sum_out/carry_out stable, in_ready=0. Raise out_ready → IDLE next edge, in_ready=1.
- in_valid held high with changing operands during SHIFT → only the operands from the accept edge affect the result. 0x10+0x20 yields 0x30.
- rst asserted on the 4th SHIFT edge of 0xAA+0x55 → next cycle state IDLE, out_valid=0, sum_out=0, carry_out=0. A following 0x01+0x01 gives 0x02.
- SERIAL_ADD_OVF_EN defined, 0x7F + 0x01 → sum_out=0x80, carry_out=0, ovf_out=1. Without the macro, the same stimulus gives the same sum_out/carry_out.
